mem_access_stage: RTL and testbench

Memory-access stage of the RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. Performs loads and stores on the data-memory port with a req/ready handshake, and stalls the upstream pipeline while an access is outstanding. Produces the sign/zero-extended load word (`wrap_load`) and the gated `reg_write` that the MEM/WB register captures.

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/dmem_if.sv | 24 ++
 rtl/load_formatter.sv | 36 +++
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, funct3 encodings and store-lane helpers for the
//                memory-access stage.
//  Contents    : lsu_state_t  - access FSM states
//                LB..SW       - funct3 access-size/sign codes
//                store_mask   - byte enables for a store
//                store_wdata  - lane-replicated store data
//                is_aligned   - natural-alignment check for an access
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // funct3[1:0] carries the access size; funct3[2] only selects sign.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   store_mask = 4'b0001 << addr_lo;
            2'b01:   store_mask = 4'b0011 << {addr_lo[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // Replicate the low byte/half into every lane so the mask alone selects it.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~addr_lo[0];
            default: is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_if
//  Description : Data-memory request/ready bus.
//  Signals     : req/we/addr/wdata/wmask - request side (stage -> memory)
//                ready/rdata             - completion side (memory -> stage)
//  Modports    : master - memory-access stage, slave - data memory
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, wmask,
                    input  ready, rdata);
    modport slave  (input  req, we, addr, wdata, wmask,
                    output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : load_formatter
//  Description : Combinational load-data alignment and sign/zero extension.
//  Ports       : rdata   in  32 - raw word from data memory
//                funct3  in   3 - access size/sign
//                addr_lo in   2 - byte lane of the access
//                data    out 32 - formatted load value
//  Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
    import lsu_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  addr_lo,
    output logic      [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[8*addr_lo +: 8];
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      data = {{24{w_byte[7]}}, w_byte};
            LH:      data = {{16{w_half[15]}}, w_half};
            LBU:     data = {24'h0, w_byte};
            LHU:     data = {16'h0, w_half};
            default: data = rdata;   // LW and the unused encodings
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : Pipeline MEM stage. Issues loads/stores on the data-memory
//                bus, stalls upstream while an access is outstanding, and
//                produces the formatted load word and gated register write.
//  Ports       : clk, rst (sync, active-low)
//                ex_valid, mem_read, mem_write, funct3, alu_res, store_data,
//                reg_write_in                 - from EX/MEM
//                dmem (dmem_if.master)        - data-memory bus
//                stall                        - hold upstream stages
//                wrap_load, reg_write_out     - to MEM/WB
//                misalign, bus_fault          - exception flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        ex_valid,
    input  wire logic        mem_read,
    input  wire logic        mem_write,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] alu_res,
    input  wire logic [31:0] store_data,
    input  wire logic        reg_write_in,
    dmem_if.master           dmem,
    output logic             stall,
    output logic      [31:0] wrap_load,
    output logic             reg_write_out,
    output logic             misalign,
    output logic             bus_fault
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wrap_load;
    logic              r_fault;
    logic              w_stall;
    logic [31:0]       w_load_fmt;

    wire logic w_mem_op  = ex_valid & (mem_read | mem_write);
    wire logic w_aligned = is_aligned(funct3, alu_res[1:0]);
    wire logic w_accept  = (r_state == IDLE) & w_mem_op & w_aligned;
    // Counter value in the last BUSY cycle allowed before giving up.
    wire logic w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Inputs are only meaningful in IDLE; in BUSY/DONE the held instruction
    // was already found aligned.
    assign misalign      = (r_state == IDLE) & w_mem_op & ~w_aligned;
    assign bus_fault     = r_fault;
    assign reg_write_out = reg_write_in & ~misalign & ~bus_fault;
    assign stall         = rst & w_stall;
    assign wrap_load     = r_wrap_load;

    assign dmem.req   = r_req;
    assign dmem.we    = r_we;
    assign dmem.addr  = r_addr;
    assign dmem.wdata = r_wdata;
    assign dmem.wmask = r_wmask;

    load_formatter u_load_formatter (
        .rdata   (dmem.rdata),
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .data    (w_load_fmt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stall      = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (dmem.ready || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_wrap_load <= '0;
            r_fault     <= 1'b0;
        end else begin
            // Fault is a one-cycle pulse covering DONE only.
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req     <= 1'b1;
                        r_we      <= mem_write;
                        r_addr    <= {alu_res[31:2], 2'b00};
                        r_wdata   <= store_wdata(funct3, store_data);
                        r_wmask   <= store_mask(funct3, alu_res[1:0]);
                        r_funct3  <= funct3;
                        r_addr_lo <= alu_res[1:0];
                        r_cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (dmem.ready) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_wrap_load <= w_load_fmt;
                        end
                    end else if (w_timeout) begin
                        r_req       <= 1'b0;
                        r_fault     <= 1'b1;
                        r_wrap_load <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE:    r_cnt <= '0;
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage. Expected
//                load words are queued when an access is driven and compared
//                when the stage reaches DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_res = '0;
    logic [31:0] store_data = '0;
    logic        reg_write_in = 1'b0;
    logic        stall;
    logic [31:0] wrap_load;
    logic        reg_write_out;
    logic        misalign;
    logic        bus_fault;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    dmem_if dmem ();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .alu_res       (alu_res),
        .store_data    (store_data),
        .reg_write_in  (reg_write_in),
        .dmem          (dmem),
        .stall         (stall),
        .wrap_load     (wrap_load),
        .reg_write_out (reg_write_out),
        .misalign      (misalign),
        .bus_fault     (bus_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        ex_valid     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write_in = 1'b0;
        dmem.ready   = 1'b0;
    endtask

    // Drives one aligned access in the next cycle, answers it after `waits`
    // BUSY cycles (negative: never), then checks DONE against the queue head.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdata,
                          input int waits, input logic rw,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                          input int exp_stall, input logic exp_fault);
        int          stalls;
        int          busy;
        bit          done;
        logic [31:0] exp_load;
        @(posedge clk); #1;
        ex_valid     = 1'b1;
        mem_read     = rd;
        mem_write    = wr;
        funct3       = f3;
        alu_res      = addr;
        store_data   = sd;
        reg_write_in = rw;
        dmem.rdata   = rdata;
        dmem.ready   = 1'b0;
        #1;
        check({tag, "/idle_stall"}, stall, 1);
        check({tag, "/idle_req"}, dmem.req, 0);
        stalls = 1;
        busy   = 0;
        done   = 0;
        for (int c = 0; c < TO + 10 && !done; c++) begin
            @(posedge clk); #1;
            if (!stall) begin
                done = 1;
            end else begin
                stalls++;
                check({tag, "/busy_req"}, dmem.req, 1);
                if (busy == 0) begin
                    check({tag, "/we"}, dmem.we, wr);
                    check({tag, "/addr"}, dmem.addr, {addr[31:2], 2'b00});
                    if (wr) begin
                        check({tag, "/wmask"}, dmem.wmask, exp_mask);
                        check({tag, "/wdata"}, dmem.wdata, exp_wdata);
                    end
                end
                dmem.ready = (waits >= 0 && busy == waits);
                busy++;
            end
        end
        dmem.ready = 1'b0;
        check({tag, "/completed"}, done, 1);
        check({tag, "/stall_cycles"}, stalls, exp_stall);
        if (exp_q.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 1, 0);
        end else begin
            exp_load = exp_q.pop_front();
            check({tag, "/wrap_load"}, wrap_load, exp_load);
        end
        check({tag, "/bus_fault"}, bus_fault, exp_fault);
        check({tag, "/reg_write_out"}, reg_write_out, rw & ~exp_fault);
        check({tag, "/done_req"}, dmem.req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem.ready = 1'b0;
        dmem.rdata = '0;

        // Reset, with a memory op presented: stall must stay low.
        ex_valid = 1'b1;
        mem_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst/stall", stall, 0);
        check("rst/req", dmem.req, 0);
        check("rst/we", dmem.we, 0);
        check("rst/addr", dmem.addr, 0);
        check("rst/wdata", dmem.wdata, 0);
        check("rst/wmask", dmem.wmask, 0);
        check("rst/wrap_load", wrap_load, 0);
        check("rst/bus_fault", bus_fault, 0);
        ex_valid = 1'b0;
        mem_read = 1'b0;
        rst = 1'b1;

        // LB sign-extend, lane 3
        exp_q.push_back(32'hFFFF_FF80);
        run_op("lb", 1, 0, LB, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1,
               4'h0, 32'h0, 2, 0);

        // SH upper half, 3 wait cycles; store leaves wrap_load alone
        exp_q.push_back(32'hFFFF_FF80);
        run_op("sh", 0, 1, SH, 32'h0000_0202, 32'h0000_BEEF, 32'hDEAD_DEAD, 3, 0,
               4'b1100, 32'hBEEF_BEEF, 5, 0);

        // LH sign-extend upper half
        exp_q.push_back(32'hFFFF_8001);
        run_op("lh", 1, 0, LH, 32'h0000_0206, 32'h0, 32'h8001_7FFF, 1, 1,
               4'h0, 32'h0, 3, 0);
        go_idle();

        // Misaligned LW
        ex_valid     = 1'b1;
        mem_read     = 1'b1;
        funct3       = LW;
        alu_res      = 32'h0000_0301;
        reg_write_in = 1'b1;
        #1;
        check("mis_lw/misalign", misalign, 1);
        check("mis_lw/stall", stall, 0);
        check("mis_lw/reg_write_out", reg_write_out, 0);
        @(posedge clk); #1;
        check("mis_lw/req", dmem.req, 0);
        check("mis_lw/stall_next", stall, 0);

        // Misaligned SH at an odd address
        mem_read  = 1'b0;
        mem_write = 1'b1;
        funct3    = SH;
        alu_res   = 32'h0000_0203;
        #1;
        check("mis_sh/misalign", misalign, 1);

        // Non-memory op passes straight through
        mem_write = 1'b0;
        #1;
        check("alu/stall", stall, 0);
        check("alu/misalign", misalign, 0);
        check("alu/reg_write_out", reg_write_out, 1);
        go_idle();

        // Reset in the second BUSY cycle
        @(posedge clk); #1;
        ex_valid     = 1'b1;
        mem_read     = 1'b1;
        funct3       = LW;
        alu_res      = 32'h0000_0600;
        reg_write_in = 1'b1;
        @(posedge clk); #1;
        check("rstbusy/req1", dmem.req, 1);
        @(posedge clk); #1;
        rst      = 1'b0;
        ex_valid = 1'b0;
        mem_read = 1'b0;
        @(posedge clk); #1;
        check("rstbusy/req", dmem.req, 0);
        check("rstbusy/stall", stall, 0);
        check("rstbusy/wrap_load", wrap_load, 0);
        check("rstbusy/bus_fault", bus_fault, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstbusy/bus_fault_after", bus_fault, 0);
        check("rstbusy/req_after", dmem.req, 0);

        // Back-to-back LBU then SW
        exp_q.push_back(32'h0000_009A);
        run_op("lbu", 1, 0, LBU, 32'h0000_0402, 32'h0, 32'h119A_2233, 0, 1,
               4'h0, 32'h0, 2, 0);
        exp_q.push_back(32'h0000_009A);
        run_op("sw", 0, 1, SW, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 0, 0,
               4'b1111, 32'hCAFE_F00D, 2, 0);

        // Timeout: never ready
        exp_q.push_back(32'h0);
        run_op("timeout", 1, 0, LW, 32'h0000_0500, 32'h0, 32'h1234_5678, -1, 1,
               4'h0, 32'h0, TO + 1, 1);
        go_idle();
        #1;
        check("timeout/fault_pulse_end", bus_fault, 0);
        check("timeout/stall_idle", stall, 0);

        check("scoreboard/drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
